// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU function codes,
// branch-type codes, control-bundle bit positions and the redirect rule.
package id_ex_operand_stage_pkg;

  typedef enum logic [3:0] {
    ALU_FN_ADD  = 4'd0,
    ALU_FN_SUB  = 4'd1,
    ALU_FN_AND  = 4'd2,
    ALU_FN_OR   = 4'd3,
    ALU_FN_XOR  = 4'd4,
    ALU_FN_SLL  = 4'd5,
    ALU_FN_SRL  = 4'd6,
    ALU_FN_SRA  = 4'd7,
    ALU_FN_SLT  = 4'd8,
    ALU_FN_SLTU = 4'd9
  } alu_fn_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'd0,
    BR_NE = 2'd1,
    BR_GE = 2'd2,
    BR_LT = 2'd3
  } br_type_e;

  localparam int CTRL_W     = 9;
  localparam int CTRL_MEM_W = 4;

  // Bit positions inside id_ctrl / ctrl_q
  localparam int CTRL_SRC_B_IMM = 8;
  localparam int CTRL_SRC_A_PC  = 7;
  localparam int CTRL_IS_BRANCH = 6;
  localparam int CTRL_IS_JAL    = 5;
  localparam int CTRL_IS_JALR   = 4;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_REG_WRITE = 0;

  function automatic logic redirect_req(input logic [CTRL_W-1:0] ctrl,
                                        input logic              bcond);
    return ctrl[CTRL_IS_JAL] | ctrl[CTRL_IS_JALR] |
           (ctrl[CTRL_IS_BRANCH] & bcond);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Operand forwarding mux: EX/MEM result wins over MEM/WB, which wins over
// the register-file value; register x0 never takes a forwarded value.
module fwd_select #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  logic hit_exmem_s;
  logic hit_memwb_s;

  assign hit_exmem_s = exmem_reg_write && (exmem_rd != {REG_ADDR_WIDTH{1'b0}}) &&
                       (exmem_rd == rs);
  assign hit_memwb_s = memwb_reg_write && (memwb_rd != {REG_ADDR_WIDTH{1'b0}}) &&
                       (memwb_rd == rs);

  always_comb begin
    fwd_data = rs_data;
    if (hit_exmem_s) begin
      fwd_data = exmem_result;
    end else if (hit_memwb_s) begin
      fwd_data = memwb_result;
    end else begin
      fwd_data = rs_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage forwarding, ALU operand select and
// branch/jump redirect resolution for an always-not-taken front end.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
  input  logic [CTRL_W-1:0]         id_ctrl,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  input  logic                      alu_bcond,
  output logic [ALU_OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0]     alu_in_1,
  output logic [DATA_WIDTH-1:0]     alu_in_2,
  output logic                      ex_valid,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [CTRL_MEM_W-1:0]     ex_ctrl_mem,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [DATA_WIDTH-1:0]     ex_link,
  output logic                      ex_redirect,
  output logic [DATA_WIDTH-1:0]     ex_target
);

  logic                      valid_q,    valid_d;
  logic [DATA_WIDTH-1:0]     pc_q,       pc_d;
  logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]     rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0]     imm_q,      imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q,      rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q,      rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,       rd_d;
  logic [ALU_OP_WIDTH-1:0]   alu_op_q,   alu_op_d;
  logic [CTRL_W-1:0]         ctrl_q,     ctrl_d;

  logic [DATA_WIDTH-1:0]     fwd_rs1_s;
  logic [DATA_WIDTH-1:0]     fwd_rs2_s;
  logic [DATA_WIDTH-1:0]     jalr_sum_s;

  // Next-state select: flush inserts a bubble, stall holds, otherwise load ID
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    alu_op_d   = alu_op_q;
    ctrl_d     = ctrl_q;
    if (flush) begin
      valid_d    = 1'b0;
      pc_d       = {DATA_WIDTH{1'b0}};
      rs1_data_d = {DATA_WIDTH{1'b0}};
      rs2_data_d = {DATA_WIDTH{1'b0}};
      imm_d      = {DATA_WIDTH{1'b0}};
      rs1_d      = {REG_ADDR_WIDTH{1'b0}};
      rs2_d      = {REG_ADDR_WIDTH{1'b0}};
      rd_d       = {REG_ADDR_WIDTH{1'b0}};
      alu_op_d   = {ALU_OP_WIDTH{1'b0}};
      ctrl_d     = {CTRL_W{1'b0}};
    end else if (stall) begin
      valid_d    = valid_q;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      alu_op_d   = id_alu_op;
      ctrl_d     = id_ctrl;
    end
  end

  // ID/EX pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= {DATA_WIDTH{1'b0}};
      rs1_data_q <= {DATA_WIDTH{1'b0}};
      rs2_data_q <= {DATA_WIDTH{1'b0}};
      imm_q      <= {DATA_WIDTH{1'b0}};
      rs1_q      <= {REG_ADDR_WIDTH{1'b0}};
      rs2_q      <= {REG_ADDR_WIDTH{1'b0}};
      rd_q       <= {REG_ADDR_WIDTH{1'b0}};
      alu_op_q   <= {ALU_OP_WIDTH{1'b0}};
      ctrl_q     <= {CTRL_W{1'b0}};
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_op_q   <= alu_op_d;
      ctrl_q     <= ctrl_d;
    end
  end

  fwd_select #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .rs              (rs1_q),
    .rs_data         (rs1_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs1_s)
  );

  fwd_select #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .rs              (rs2_q),
    .rs_data         (rs2_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs2_s)
  );

  assign jalr_sum_s = fwd_rs1_s + imm_q;

  // EX-stage outputs; memory control and link value are suppressed for bubbles
  always_comb begin
    alu_op        = alu_op_q;
    ex_valid      = valid_q;
    ex_rd         = rd_q;
    ex_store_data = fwd_rs2_s;
    alu_in_1      = fwd_rs1_s;
    alu_in_2      = fwd_rs2_s;
    ex_ctrl_mem   = {CTRL_MEM_W{1'b0}};
    ex_link       = {DATA_WIDTH{1'b0}};
    ex_redirect   = 1'b0;
    ex_target     = pc_q + imm_q;

    if (ctrl_q[CTRL_SRC_A_PC]) begin
      alu_in_1 = pc_q;
    end else begin
      alu_in_1 = fwd_rs1_s;
    end

    if (ctrl_q[CTRL_SRC_B_IMM]) begin
      alu_in_2 = imm_q;
    end else begin
      alu_in_2 = fwd_rs2_s;
    end

    if (valid_q) begin
      ex_ctrl_mem = ctrl_q[CTRL_MEM_W-1:0];
      ex_link     = pc_q + {{(DATA_WIDTH-3){1'b0}}, 3'd4};
      ex_redirect = redirect_req(ctrl_q, alu_bcond);
    end else begin
      ex_ctrl_mem = {CTRL_MEM_W{1'b0}};
      ex_link     = {DATA_WIDTH{1'b0}};
      ex_redirect = 1'b0;
    end

    // jalr clears bit 0 of the computed address
    if (ctrl_q[CTRL_IS_JALR]) begin
      ex_target = {jalr_sum_s[DATA_WIDTH-1:1], 1'b0};
    end else begin
      ex_target = pc_q + imm_q;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: each cycle's stimulus pushes the expected EX outputs from
// an abstract slot model; a negedge monitor pops and compares.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [5:0]  id_alu_op;
  logic [8:0]  id_ctrl;
  logic        exmem_reg_write, memwb_reg_write, alu_bcond;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [5:0]  alu_op;
  logic [31:0] alu_in_1, alu_in_2, ex_store_data, ex_link, ex_target;
  logic        ex_valid, ex_redirect;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_ctrl_mem;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_bcond(alu_bcond), .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_ctrl_mem(ex_ctrl_mem),
    .ex_store_data(ex_store_data), .ex_link(ex_link), .ex_redirect(ex_redirect),
    .ex_target(ex_target)
  );

  typedef struct packed {
    logic        reset, stall, flush, valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  op;
    logic [8:0]  ctrl;
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        bcond;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  op;
    logic [8:0]  ctrl;
  } slot_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] in1, in2;
    logic [4:0]  rd;
    logic [3:0]  cm;
    logic [31:0] sd, link;
    logic        red;
    logic [31:0] tgt;
  } exp_t;

  // ctrl = {src_b_imm, src_a_pc, branch, jal, jalr, mem_read, mem_write, mem_to_reg, reg_write}
  localparam logic [8:0] C_ALU  = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] C_BEQ  = 9'b0_0_1_0_0_0_0_0_0;
  localparam logic [8:0] C_JALR = 9'b1_0_0_0_1_0_0_0_1;

  slot_t slot;
  exp_t  sb_q[$];
  int    tests = 0, fails = 0, pushed = 0, popped = 0;
  bit    mon_en = 1'b0;

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d, input stim_t x);
    if (x.ew && x.erd != 5'd0 && x.erd == rs) return x.eres;
    if (x.mw && x.mrd != 5'd0 && x.mrd == rs) return x.mres;
    return d;
  endfunction

  function automatic exp_t model(input slot_t s, input stim_t x);
    exp_t e;
    logic [31:0] f1, f2;
    f1 = fwd(s.rs1, s.d1, x);
    f2 = fwd(s.rs2, s.d2, x);
    e.valid = s.valid;
    e.op    = s.op;
    e.in1   = s.ctrl[7] ? s.pc : f1;
    e.in2   = s.ctrl[8] ? s.imm : f2;
    e.rd    = s.rd;
    e.cm    = s.valid ? s.ctrl[3:0] : 4'd0;
    e.sd    = f2;
    e.link  = s.valid ? s.pc + 32'd4 : 32'd0;
    e.red   = s.valid && (s.ctrl[5] || s.ctrl[4] || (s.ctrl[6] && x.bcond));
    e.tgt   = s.ctrl[4] ? ((f1 + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
    return e;
  endfunction

  function automatic slot_t next_slot(input slot_t s, input stim_t x);
    slot_t n;
    if (x.reset || x.flush) begin
      n = '0;
    end else if (x.stall) begin
      n = s;
    end else begin
      n.valid = x.valid; n.pc = x.pc; n.d1 = x.d1; n.d2 = x.d2; n.imm = x.imm;
      n.rs1 = x.rs1; n.rs2 = x.rs2; n.rd = x.rd; n.op = x.op; n.ctrl = x.ctrl;
    end
    return n;
  endfunction

  function automatic stim_t idle();
    stim_t x;
    x = '0;
    return x;
  endfunction

  function automatic stim_t rand_stim();
    stim_t x;
    x.reset = ($urandom_range(0, 39) == 0);
    x.flush = ($urandom_range(0, 9) == 0);
    x.stall = ($urandom_range(0, 5) == 0);
    x.valid = ($urandom_range(0, 3) != 0);
    x.pc    = {$urandom(), 2'b00} >> 2 << 2;
    x.d1    = $urandom();
    x.d2    = $urandom();
    x.imm   = $urandom();
    x.rs1   = 5'($urandom_range(0, 3));
    x.rs2   = 5'($urandom_range(0, 3));
    x.rd    = 5'($urandom_range(0, 31));
    x.op    = 6'($urandom());
    x.ctrl  = 9'($urandom());
    x.ew    = 1'($urandom());
    x.erd   = 5'($urandom_range(0, 3));
    x.eres  = $urandom();
    x.mw    = 1'($urandom());
    x.mrd   = 5'($urandom_range(0, 3));
    x.mres  = $urandom();
    x.bcond = 1'($urandom());
    return x;
  endfunction

  task automatic drive(input stim_t x);
    reset = x.reset; stall = x.stall; flush = x.flush; id_valid = x.valid;
    id_pc = x.pc; id_rs1_data = x.d1; id_rs2_data = x.d2; id_imm = x.imm;
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd; id_alu_op = x.op; id_ctrl = x.ctrl;
    exmem_reg_write = x.ew; exmem_rd = x.erd; exmem_result = x.eres;
    memwb_reg_write = x.mw; memwb_rd = x.mrd; memwb_result = x.mres;
    alu_bcond = x.bcond;
  endtask

  task automatic step(input stim_t x);
    @(posedge clk);
    #1;
    drive(x);
    sb_q.push_back(model(slot, x));
    pushed++;
    slot = next_slot(slot, x);
    mon_en = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        popped++;
        chk("ex_valid",      {31'd0, ex_valid},    {31'd0, e.valid});
        chk("alu_op",        {26'd0, alu_op},      {26'd0, e.op});
        chk("alu_in_1",      alu_in_1,             e.in1);
        chk("alu_in_2",      alu_in_2,             e.in2);
        chk("ex_rd",         {27'd0, ex_rd},       {27'd0, e.rd});
        chk("ex_ctrl_mem",   {28'd0, ex_ctrl_mem}, {28'd0, e.cm});
        chk("ex_store_data", ex_store_data,        e.sd);
        chk("ex_link",       ex_link,              e.link);
        chk("ex_redirect",   {31'd0, ex_redirect}, {31'd0, e.red});
        if (e.red) chk("ex_target", ex_target, e.tgt);
      end
    end
  end

  initial begin
    stim_t x;
    drive(idle());
    reset = 1'b1;
    repeat (2) @(posedge clk);
    slot = '0;

    // Reset with a valid ID instruction present
    x = idle(); x.reset = 1'b1; x.valid = 1'b1; x.ctrl = 9'h1FF; x.op = 6'h3F; x.pc = 32'h40;
    step(x);
    // Load rs1=5 instruction; this cycle checks the reset bubble
    x = idle(); x.valid = 1'b1; x.rs1 = 5'd5; x.d1 = 32'hAAA; x.rd = 5'd9; x.ctrl = C_ALU; x.op = 6'h04;
    step(x);
    // EX/MEM wins over MEM/WB
    x = idle(); x.stall = 1'b1; x.ew = 1'b1; x.erd = 5'd5; x.eres = 32'h11;
    x.mw = 1'b1; x.mrd = 5'd5; x.mres = 32'h22;
    step(x);
    // MEM/WB when EX/MEM does not write
    x.ew = 1'b0;
    step(x);
    // Load rs1=0 instruction
    x = idle(); x.valid = 1'b1; x.rs1 = 5'd0; x.d1 = 32'h55; x.ctrl = C_ALU;
    step(x);
    // x0 never forwards
    x = idle(); x.ew = 1'b1; x.erd = 5'd0; x.eres = 32'h99; x.mw = 1'b1; x.mrd = 5'd0; x.mres = 32'h77;
    x.valid = 1'b1; x.pc = 32'h100; x.imm = 32'h20; x.ctrl = C_BEQ;
    step(x);
    // beq taken, held by stall
    x = idle(); x.stall = 1'b1; x.bcond = 1'b1;
    step(x);
    // beq not taken; then load jalr
    x = idle(); x.bcond = 1'b0; x.valid = 1'b1; x.pc = 32'h300; x.rs1 = 5'd7;
    x.d1 = 32'h203; x.imm = 32'h4; x.rd = 5'd1; x.ctrl = C_JALR;
    step(x);
    // jalr executes: target 0x206, link 0x304; load next instruction
    x = idle(); x.valid = 1'b1; x.pc = 32'h400; x.rs1 = 5'd2; x.d1 = 32'h1234; x.rd = 5'd3; x.ctrl = C_ALU;
    step(x);
    // Two stall cycles with different ID contents: outputs held
    for (int i = 0; i < 2; i++) begin
      x = idle(); x.stall = 1'b1; x.valid = 1'b1; x.pc = 32'h500 + 32'(i); x.ctrl = 9'h1FF;
      step(x);
    end
    // Stall and flush together: bubble
    x = idle(); x.stall = 1'b1; x.flush = 1'b1; x.valid = 1'b1; x.ctrl = 9'h1FF;
    step(x);
    // Load resumes
    x = idle(); x.valid = 1'b1; x.pc = 32'h600; x.rs2 = 5'd4; x.d2 = 32'hBEEF; x.ctrl = 9'b0_0_0_0_0_0_1_0_0;
    step(x);
    step(idle());

    for (int i = 0; i < 400; i++) step(rand_stim());
    step(idle());

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drain", 32'(popped), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
